// File: rtl/key_conditioner_pkg.sv
// Shared constants and types for the push-button conditioning block.
package key_conditioner_pkg;

  // Default timing at 50 MHz: 20 ms debounce, 500 ms hold, 200 ms repeat.
  localparam int KEY_DEBOUNCE_CYCLES = 1_000_000;
  localparam int KEY_HOLD_CYCLES     = 25_000_000;
  localparam int KEY_REPEAT_CYCLES   = 10_000_000;

  // Hold/auto-repeat sequencer states.
  typedef enum logic [1:0] {
    KEY_IDLE   = 2'd0,
    KEY_HELD   = 2'd1,
    KEY_REPEAT = 2'd2
  } key_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_channel.sv
// One key: two-flop synchronizer, debouncer and hold/auto-repeat sequencer.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// KEY_IDLE   | key released (or not yet debounced as pressed)
// KEY_HELD   | pressed, counting toward the first repeat strobe
// KEY_REPEAT | still held, emitting a repeat strobe every REPEAT_CYCLES
module key_channel
  import key_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = KEY_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = KEY_HOLD_CYCLES,
  parameter int REPEAT_CYCLES   = KEY_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_repeat
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(max_int(HOLD_CYCLES, REPEAT_CYCLES));

  localparam logic [DW-1:0] D_TC = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] H_TC = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] R_TC = HW'(REPEAT_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic [DW-1:0] dcnt;
  logic          toggle;
  logic          rise;
  logic          fall;

  key_state_t    state;
  key_state_t    state_nx;
  logic [HW-1:0] hcnt;
  logic [HW-1:0] hcnt_nx;
  logic          repeat_nx;

  // Level changes are accepted only after DEBOUNCE_CYCLES consecutive
  // disagreeing samples; rise/fall mark the edge at which it happens.
  always_comb begin
    toggle = (s2 != key_level) && (dcnt == D_TC);
    rise   = toggle && !key_level;
    fall   = toggle && key_level;
  end

  // Synchronizer, debounce counter, level and press/release strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1          <= 1'b0;
      s2          <= 1'b0;
      dcnt        <= '0;
      key_level   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      s1          <= ~key_n;
      s2          <= s1;
      key_press   <= rise;
      key_release <= fall;
      if ((s2 == key_level) || toggle) begin
        dcnt <= '0;
      end else begin
        dcnt <= dcnt + DW'(1);
      end
      if (toggle) begin
        key_level <= ~key_level;
      end
    end
  end

  // Hold sequencer next state; the release edge overrides any expiring count
  // so a repeat never lands on the release cycle.
  always_comb begin
    state_nx  = state;
    hcnt_nx   = hcnt + HW'(1);
    repeat_nx = 1'b0;
    case (state)
      KEY_IDLE: begin
        hcnt_nx = '0;
        if (rise) begin
          state_nx = KEY_HELD;
        end
      end
      KEY_HELD: begin
        if (hcnt == H_TC) begin
          repeat_nx = 1'b1;
          hcnt_nx   = '0;
          state_nx  = KEY_REPEAT;
        end
      end
      KEY_REPEAT: begin
        if (hcnt == R_TC) begin
          repeat_nx = 1'b1;
          hcnt_nx   = '0;
        end
      end
      default: begin
        state_nx = KEY_IDLE;
        hcnt_nx  = '0;
      end
    endcase
    if (fall) begin
      state_nx  = KEY_IDLE;
      hcnt_nx   = '0;
      repeat_nx = 1'b0;
    end
  end

  // Hold sequencer state, counter and registered repeat strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= KEY_IDLE;
      hcnt       <= '0;
      key_repeat <= 1'b0;
    end else begin
      state      <= state_nx;
      hcnt       <= hcnt_nx;
      key_repeat <= repeat_nx;
    end
  end

endmodule

// File: rtl/key_conditioner.sv
// Conditions N_KEYS raw active-low push-buttons into debounced levels and
// single-cycle press/release/repeat strobes; keys are fully independent.
module key_conditioner
  import key_conditioner_pkg::*;
#(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = KEY_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = KEY_HOLD_CYCLES,
  parameter int REPEAT_CYCLES   = KEY_REPEAT_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_n,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_repeat
);

  // One independent channel per key.
  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    key_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .HOLD_CYCLES    (HOLD_CYCLES),
      .REPEAT_CYCLES  (REPEAT_CYCLES)
    ) u_channel (
      .clk        (clk),
      .rst        (rst),
      .key_n      (key_n[i]),
      .key_level  (key_level[i]),
      .key_press  (key_press[i]),
      .key_release(key_release[i]),
      .key_repeat (key_repeat[i])
    );
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with DEBOUNCE=4, HOLD=10, REPEAT=3.
module tb_key_conditioner;

  logic       clk;
  logic       rst;
  logic [3:0] key_n;
  logic [3:0] key_level;
  logic [3:0] key_press;
  logic [3:0] key_release;
  logic [3:0] key_repeat;

  int checks   = 0;
  int failures = 0;

  key_conditioner #(
    .N_KEYS         (4),
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES    (10),
    .REPEAT_CYCLES  (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_n      (key_n),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .key_repeat (key_repeat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; outputs are sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] el, input logic [3:0] ep,
                         input logic [3:0] er, input logic [3:0] et);
    chk({tag, "_level"},   key_level,   el);
    chk({tag, "_press"},   key_press,   ep);
    chk({tag, "_release"}, key_release, er);
    chk({tag, "_repeat"},  key_repeat,  et);
  endtask

  initial begin
    logic [3:0] el, ep, er, et;

    // Reset with all keys released.
    rst   = 1'b1;
    key_n = 4'hF;
    tick(); tick(); tick();
    chk_all("reset", 4'b0, 4'b0, 4'b0, 4'b0);
    rst = 1'b0;
    tick();
    chk_all("post_reset", 4'b0, 4'b0, 4'b0, 4'b0);

    // Key 0: clean press, level and strobe at edge 5.
    key_n[0] = 1'b0;
    for (int e = 0; e <= 6; e++) begin
      tick();
      el = (e >= 5) ? 4'b0001 : 4'b0000;
      ep = (e == 5) ? 4'b0001 : 4'b0000;
      chk_all("k0_press", el, ep, 4'b0, 4'b0);
    end
    // Key 0 released before its first repeat; no repeat afterwards.
    key_n[0] = 1'b1;
    for (int e = 0; e <= 11; e++) begin
      tick();
      el = (e < 5) ? 4'b0001 : 4'b0000;
      er = (e == 5) ? 4'b0001 : 4'b0000;
      chk_all("k0_release", el, 4'b0, er, 4'b0);
    end

    // Key 1: low 3, high 1, then low steady; press 5 edges after final fall.
    key_n[1] = 1'b0;
    for (int e = 0; e <= 9; e++) begin
      if (e == 3) key_n[1] = 1'b1;
      if (e == 4) key_n[1] = 1'b0;
      tick();
      el = (e >= 9) ? 4'b0010 : 4'b0000;
      ep = (e == 9) ? 4'b0010 : 4'b0000;
      chk_all("k1_bounce", el, ep, 4'b0, 4'b0);
    end
    key_n[1] = 1'b1;
    for (int e = 0; e <= 9; e++) begin
      tick();
      el = (e < 5) ? 4'b0010 : 4'b0000;
      er = (e == 5) ? 4'b0010 : 4'b0000;
      chk_all("k1_release", el, 4'b0, er, 4'b0);
    end

    // Key 2: long hold, repeats at press+10,+13,...; release lands on a repeat slot.
    key_n[2] = 1'b0;
    for (int e = 0; e <= 60; e++) begin
      if (e == 40) key_n[2] = 1'b1;
      tick();
      el = (e >= 5 && e < 45) ? 4'b0100 : 4'b0000;
      ep = (e == 5) ? 4'b0100 : 4'b0000;
      er = (e == 45) ? 4'b0100 : 4'b0000;
      et = (e >= 15 && e < 45 && ((e - 15) % 3 == 0)) ? 4'b0100 : 4'b0000;
      chk_all("k2_hold", el, ep, er, et);
    end

    // Keys 0 and 1 pressed one cycle apart, held into REPEAT.
    key_n[0] = 1'b0;
    for (int e = 0; e <= 19; e++) begin
      if (e == 1) key_n[1] = 1'b0;
      tick();
      el = {2'b00, (e >= 6), (e >= 5)};
      ep = {2'b00, (e == 6), (e == 5)};
      et = {2'b00, (e == 16 || e == 19), (e == 15 || e == 18)};
      chk_all("k01_offset", el, ep, 4'b0, et);
    end

    // Reset mid-repeat with both keys still held.
    rst = 1'b1;
    tick();
    chk_all("rst_hold", 4'b0, 4'b0, 4'b0, 4'b0);
    rst = 1'b0;
    for (int f = 1; f <= 20; f++) begin
      tick();
      el = (f >= 6) ? 4'b0011 : 4'b0000;
      ep = (f == 6) ? 4'b0011 : 4'b0000;
      et = (f == 16 || f == 19) ? 4'b0011 : 4'b0000;
      chk_all("after_rst", el, ep, 4'b0, et);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
